// File: rtl/frame_pkg.sv
// Shared frame-control definitions: default raster size, address width, pixel type and
// the Wait/Busy/Drain/Done state encoding used by the frame readers and writers.
package frame_pkg;

    localparam int H_TOTAL_DEF = 640;
    localparam int V_TOTAL_DEF = 480;
    localparam int ADDR_W      = 19;
    localparam int PIX_W_DEF   = 16;

    typedef logic [PIX_W_DEF-1:0] pix_t;

    typedef enum logic [1:0] {
        Wait,
        Busy,
        Drain,
        Done
    } frame_state_t;

    // y*h as a sum of shifted copies of y; h is a constant, so this folds to a few adders.
    function automatic logic [ADDR_W-1:0] line_offset(input logic [ADDR_W-1:0] y,
                                                      input int unsigned h);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (h[i]) begin
                acc = acc + (y << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// Small show-ahead synchronous FIFO holding returned pixels with their line/frame markers.
// Head entry is visible combinationally whenever empty is low.
module frame_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [PW:0]   count_reg;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_reg[rptr_reg];
    assign count   = count_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (do_pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge Clk) begin
            if (do_push && (wptr_reg == PW'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Raster-order frame reader: issues frame-buffer reads under a credit limit and streams the
// returned pixels with sol/sof markers. Define FRAME_READER_DBUF_EN for the buf_sel front-buffer port.
module frame_reader
    import frame_pkg::*;
#(
    parameter int H_TOTAL    = H_TOTAL_DEF,
    parameter int V_TOTAL    = V_TOTAL_DEF,
    parameter int PIX_W      = $bits(pix_t),
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              read_start,
    output logic              read_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              mem_rvalid,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_sol,
    output logic              pix_sof,
    output logic              pix_valid,
    input  logic              pix_ready
`ifdef FRAME_READER_DBUF_EN
    ,
    input  logic              buf_sel
`endif
);

    localparam int XW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int YW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = PIX_W + 2;
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    frame_state_t      state_reg;
    frame_state_t      state_next;
    logic [XW-1:0]     x_reg;
    logic [XW-1:0]     x_next;
    logic [YW-1:0]     y_reg;
    logic [YW-1:0]     y_next;
    logic [XW-1:0]     rx_reg;
    logic [YW-1:0]     ry_reg;
    logic [CW-1:0]     outstanding_reg;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_flight;
    logic              fifo_empty;
    logic              issue;
    logic              accept_rv;
    logic              pop;
    logic              ret_sol;
    logic              ret_sof;
    logic [ADDR_W-1:0] base_off;
    logic [EW-1:0]     push_entry;
    logic [EW-1:0]     head_entry;

`ifdef FRAME_READER_DBUF_EN
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(H_TOTAL * V_TOTAL);
    logic base_sel_reg;

    // Buffer choice is latched once per frame so mid-frame buf_sel changes cannot tear it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            base_sel_reg <= 1'b0;
        end else if (state_reg == Wait && read_start) begin
            base_sel_reg <= buf_sel;
        end
    end

    assign base_off = base_sel_reg ? FRAME_SIZE : '0;
`else
    assign base_off = '0;
`endif

    // Reads in flight plus pixels buffered may never exceed the FIFO, so pushes cannot overflow.
    assign in_flight = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign issue     = (state_reg == Busy) && (in_flight < (CW+1)'(FIFO_DEPTH));
    assign accept_rv = mem_rvalid && (outstanding_reg != '0) && (state_reg != Wait);

    assign mem_rd    = issue;
    assign mem_addr  = issue ? (line_offset(ADDR_W'(y_reg), H_TOTAL) + ADDR_W'(x_reg) + base_off)
                             : '0;
    assign read_done = (state_reg == Done);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg       <= Wait;
            x_reg           <= '0;
            y_reg           <= '0;
            rx_reg          <= '0;
            ry_reg          <= '0;
            outstanding_reg <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            case ({issue, accept_rv})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: ;
            endcase
            // Markers follow the returned data stream, independent of how far issue has run ahead.
            if (state_reg == Wait) begin
                rx_reg <= '0;
                ry_reg <= '0;
            end else if (accept_rv) begin
                if (rx_reg == X_LAST) begin
                    rx_reg <= '0;
                    ry_reg <= (ry_reg == Y_LAST) ? '0 : ry_reg + 1'b1;
                end else begin
                    rx_reg <= rx_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        unique case (state_reg)
            Wait: begin
                x_next = '0;
                y_next = '0;
                if (read_start) begin
                    state_next = Busy;
                end
            end
            Busy: begin
                if (issue) begin
                    if (x_reg == X_LAST) begin
                        x_next = '0;
                        if (y_reg == Y_LAST) begin
                            y_next     = '0;
                            state_next = Drain;
                        end else begin
                            y_next = y_reg + 1'b1;
                        end
                    end else begin
                        x_next = x_reg + 1'b1;
                    end
                end
            end
            Drain: begin
                if (outstanding_reg == '0 && fifo_empty) begin
                    state_next = Done;
                end
            end
            Done: begin
                if (!read_start) begin
                    state_next = Wait;
                end
            end
            default: state_next = Wait;
        endcase
    end

    assign ret_sol    = (rx_reg == '0);
    assign ret_sof    = ret_sol && (ry_reg == '0);
    assign push_entry = {ret_sof, ret_sol, mem_rdata};
    assign pop        = pix_valid && pix_ready;

    frame_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (accept_rv),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pix_valid = !fifo_empty;
    assign pix_data  = fifo_empty ? '0 : head_entry[PIX_W-1:0];
    assign pix_sol   = !fifo_empty && head_entry[PIX_W];
    assign pix_sof   = !fifo_empty && head_entry[PIX_W+1];

endmodule
